// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Handshake and data bundle between a divide requester and seq_divider.
//
// Signals:
//   start    - request a divide (sampled on rising clk edge)
//   dataA    - dividend, WIDTH bits
//   dataB    - divisor, WIDTH bits
//   Signal   - 6-bit operation code
//   dataOut  - {remainder, quotient}, 2*WIDTH bits
//   busy     - an operation is iterating
//   done     - single-cycle completion pulse
//   divzero  - last completed operation had a zero divisor
//
// Modports:
//   master - the requester side (drives start/operands, reads results)
//   slave  - the divider side
// ---------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic [5:0]           Signal;
  logic [2*WIDTH-1:0]   dataOut;
  logic                 busy;
  logic                 done;
  logic                 divzero;

  modport master (
    output start, dataA, dataB, Signal,
    input  dataOut, busy, done, divzero
  );

  modport slave (
    input  start, dataA, dataB, Signal,
    output dataOut, busy, done, divzero
  );

endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider. One quotient bit is produced per clock, so
// a divide takes WIDTH edges after the accepting edge. A zero divisor skips
// the iterations and completes on the accepting edge itself.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   firstart  - asynchronous active-high reset
//   bus       - seq_divider_if.slave (start, dataA, dataB, Signal,
//               dataOut, busy, done, divzero)
//
// Parameters:
//   WIDTH       - operand width; dataOut is {remainder, quotient}
//   DIVU_FUNCT  - Signal code for unsigned divide
//
// Configuration macro:
//   DIV_SIGNED_EN - when defined, Signal == 6'b011010 also starts a signed
//                   two's-complement divide with the same latency.
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] DIVU_FUNCT = 6'b011011
) (
  input logic          clk,
  input logic          firstart,
  seq_divider_if.slave bus
);

  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
  localparam logic [5:0]    DIV_FUNCT = 6'b011010;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   dataOut_q, dataOut_d;
  logic                 divzero_q, divzero_d;
`ifdef DIV_SIGNED_EN
  logic                 negQuo_q, negQuo_d;
  logic                 negRem_q, negRem_d;
  logic                 isSigned;
`endif

  logic                 accept;
  logic                 divByZero;
  logic                 lastIter;
  logic                 stepGe;
  logic [WIDTH:0]       remWide;
  logic [WIDTH-1:0]     stepRem, stepQuo;
  logic [WIDTH-1:0]     magA, magB;
  logic [WIDTH-1:0]     resRem, resQuo;

  // Request decode. Operands are reduced to magnitudes here so the
  // iteration core is always unsigned; the signs are re-applied at the end.
  always_comb begin
    divByZero = (bus.dataB == '0);
`ifdef DIV_SIGNED_EN
    isSigned  = (bus.Signal == DIV_FUNCT);
    accept    = bus.start && (state_q == IDLE) &&
                ((bus.Signal == DIVU_FUNCT) || isSigned);
    magA      = (isSigned && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
    magB      = (isSigned && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
`else
    accept    = bus.start && (state_q == IDLE) && (bus.Signal == DIVU_FUNCT);
    magA      = bus.dataA;
    magB      = bus.dataB;
`endif
  end

  // One restoring step. The compare is one bit wider than the operands
  // because the shifted partial remainder can exceed 2^WIDTH-1 when the
  // divisor has its MSB set; the subtraction result itself always fits.
  always_comb begin
    remWide  = {rem_q, quo_q[WIDTH-1]};
    stepGe   = (remWide >= {1'b0, divisor_q});
    stepRem  = stepGe ? (remWide[WIDTH-1:0] - divisor_q) : remWide[WIDTH-1:0];
    stepQuo  = {quo_q[WIDTH-2:0], stepGe};
    lastIter = (cnt_q == LAST_ITER);
`ifdef DIV_SIGNED_EN
    resQuo   = negQuo_q ? -stepQuo : stepQuo;
    resRem   = negRem_q ? -stepRem : stepRem;
`else
    resQuo   = stepQuo;
    resRem   = stepRem;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge firstart) begin
    if (firstart) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero divisor bypasses RUN entirely; starts seen
  // outside IDLE are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = divByZero ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastIter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded straight from state.
  always_comb begin
    bus.busy    = (state_q == RUN);
    bus.done    = (state_q == DONE);
    bus.dataOut = dataOut_q;
    bus.divzero = divzero_q;
  end

  // Datapath next-state. dataOut is only written at completion so the
  // previous result stays visible for the whole of the next divide.
  always_comb begin
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    dataOut_d = dataOut_q;
    divzero_d = divzero_q;
`ifdef DIV_SIGNED_EN
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          divisor_d = magB;
          quo_d     = magA;
          rem_d     = '0;
          cnt_d     = '0;
          divzero_d = divByZero;
`ifdef DIV_SIGNED_EN
          negQuo_d  = isSigned && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
          negRem_d  = isSigned && bus.dataA[WIDTH-1];
`endif
          if (divByZero) begin
            dataOut_d = {bus.dataA, {WIDTH{1'b1}}};
          end
        end
      end
      RUN: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        cnt_d = cnt_q + CW'(1);
        if (lastIter) begin
          dataOut_d = {resRem, resQuo};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge firstart) begin
    if (firstart) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      dataOut_q <= '0;
      divzero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
`endif
    end else begin
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      dataOut_q <= dataOut_d;
      divzero_q <= divzero_d;
`ifdef DIV_SIGNED_EN
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
`endif
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand width; dataOut is 2*WIDTH.
REQ-002 Parameter DIVU_FUNCT, default 6'b011011: Signal code selecting unsigned divide.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 firstart  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a divide; sampled on rising clk edge.
REQ-006 dataA  input  WIDTH  dividend.
REQ-007 dataB  input  WIDTH  divisor.
REQ-008 Signal  input  6  operation code.
REQ-009 dataOut  output  2*WIDTH  {remainder (hi), quotient (lo)}.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 divzero  output  1  last completed operation had divisor zero; held until next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on accepted start, RUN->DONE after iteration WIDTH, DONE->IDLE unconditionally next edge.
REQ-014 A start SHALL be accepted only in IDLE with Signal==DIVU_FUNCT; otherwise ignored with no state change.
REQ-015 On accepted start (edge E0), dividend, divisor SHALL be latched; remainder register cleared; iteration counter cleared; busy=1.
REQ-016 Each RUN edge SHALL perform one restoring step: shift {rem,quo} left 1 bringing in next dividend MSB; if rem >= divisor, rem -= divisor and quo LSB=1, else quo LSB=0.
REQ-017 Subtraction compare SHALL use WIDTH+1 bits so divisor values >= 2^(WIDTH-1) are handled without overflow.
REQ-018 Iterations occur on edges E1..E32 (WIDTH=32); at E32 dataOut SHALL update and state enters DONE with done=1, busy=0.
REQ-019 done SHALL be high exactly one cycle (E32 to E33); FSM returns to IDLE at E33.
REQ-020 dataOut SHALL hold the last result until the next accepted start completes; it SHALL NOT change during RUN.
REQ-021 Divisor zero: at E0 the block SHALL go directly to DONE; at that edge dataOut={dataA, all-ones}, divzero=1; done high E0 to E1.
REQ-022 start asserted in RUN or DONE SHALL be ignored (no queuing).
REQ-023 Operands changing after E0 SHALL NOT affect the result.

Reset
REQ-024 While firstart is high: state=IDLE, dataOut=0, busy=0, done=0, divzero=0, all internal registers 0, regardless of clk.
REQ-025 firstart mid-operation SHALL abort immediately; no done pulse is produced for the aborted operation.
REQ-026 First start may be accepted on the first rising edge after firstart deasserts.

Configuration
REQ-027 Macro DIV_SIGNED_EN: when defined, Signal==6'b011010 (DIV) SHALL also be accepted and performs signed two's-complement division.
REQ-028 With DIV_SIGNED_EN: operands converted to magnitudes at E0; quotient negated if operand signs differ; remainder takes dividend sign; same latency.
REQ-029 With DIV_SIGNED_EN: -2^31 / -1 SHALL yield quotient 0x80000000, remainder 0; divide-by-zero follows REQ-021 using the raw dataA.
REQ-030 Without DIV_SIGNED_EN: Signal 6'b011010 SHALL be ignored like any unsupported code; no signed logic synthesised.

Verification
REQ-031 dataA=100, dataB=7, Signal=DIVU, start at E0 -> done at E32, dataOut={32'd2, 32'd14}, divzero=0.
REQ-032 dataA=0xFFFFFFFF, dataB=0x80000000 -> dataOut={0x7FFFFFFF, 32'd1}; dataB=1 -> {0, 0xFFFFFFFF}.
REQ-033 dataA=55, dataB=0 -> done at E0, dataOut={32'd55, 0xFFFFFFFF}, divzero=1.
REQ-034 start pulsed at E5 during RUN with different operands -> ignored; first result unchanged at E32; start with Signal=6'd0 in IDLE -> busy stays 0.
REQ-035 firstart pulsed at E10 of a divide -> dataOut=0, busy=0, no done; fresh 100/7 afterwards completes correctly.
REQ-036 With DIV_SIGNED_EN: -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1 (0xFFFFFFFF); 0x80000000/-1 -> {0, 0x80000000}.
